// File: rtl/iobus_uart_tx.sv
// IOBUS-mapped 8N1 UART transmitter: TXDATA/STATUS register window, byte FIFO,
// baud divider and serializer FSM with a registered TX output.
module iobus_uart_tx #(
  parameter int unsigned CLK_RATE   = 50,
  parameter int unsigned BAUD       = 115200,
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] RD_DATA,
  output logic        RD_SEL,
  output logic        TX
);

  localparam int unsigned DIV =
    32'((64'(CLK_RATE) * 64'd1_000_000 + 64'(BAUD / 2)) / 64'(BAUD));
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  localparam logic [31:0] DATA_ADDR = BASE_ADDR;
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tx_q;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          ovf;

  logic hit_data, hit_stat;
  logic full, empty, busy;
  logic wr_data, wr_stat;
  logic push, pop, bit_end;

  // Byte offset bits [1:0] do not participate in decode.
  assign hit_data = (IOBUS_ADDR[31:2] == DATA_ADDR[31:2]);
  assign hit_stat = (IOBUS_ADDR[31:2] == STAT_ADDR[31:2]);
  assign RD_SEL   = hit_data | hit_stat;

  assign full  = (level == LVL_FULL);
  assign empty = (level == '0);
  assign busy  = (state != ST_IDLE);

  assign wr_data = IOBUS_WR & hit_data;
  assign wr_stat = IOBUS_WR & hit_stat;
  assign push    = wr_data & ~full;
  assign bit_end = (cnt == CNT_LAST);

  // A frame is loaded either from idle or straight out of the last stop-bit cycle.
  assign pop = ~empty & ((state == ST_IDLE) | ((state == ST_STOP) & bit_end));

  always_comb begin
    RD_DATA = '0;
    if (hit_stat) begin
      RD_DATA = {20'h0_0000, 4'(level), 4'h0, ovf, busy, empty, full};
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= IOBUS_OUT[7:0];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

  // Overflow is judged on the pre-edge level, so a same-cycle pop does not rescue the write.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ovf <= 1'b0;
    end else if (wr_data && full) begin
      ovf <= 1'b1;
    end else if (wr_stat && IOBUS_OUT[3]) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
    end else if (state == ST_IDLE || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= ST_IDLE;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            state <= ST_START;
            shreg <= mem[rd_ptr];
            tx_q  <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            bit_idx <= '0;
            tx_q    <= shreg[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= {1'b0, shreg[7:1]};
              tx_q    <= shreg[1];
            end
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (!empty) begin
              state <= ST_START;
              shreg <= mem[rd_ptr];
              tx_q  <= 1'b0;
            end else begin
              state <= ST_IDLE;
              tx_q  <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  assign TX = tx_q;

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Scoreboard bench for iobus_uart_tx at DIV=4: expected bytes are queued when
// written, and a line monitor decodes TX frames and checks them against the queue.
module tb_iobus_uart_tx;

  localparam logic [31:0] BASE = 32'h1100_0100;
  localparam logic [31:0] STAT = BASE + 32'd4;

  logic        CLK;
  logic        RESET_N;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] RD_DATA;
  logic        RD_SEL;
  logic        TX;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  int unsigned n_frames = 0;
  logic [7:0]  sb [$];

  iobus_uart_tx #(
    .CLK_RATE  (1),
    .BAUD      (250000),
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(8)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .IOBUS_ADDR(IOBUS_ADDR),
    .IOBUS_OUT (IOBUS_OUT),
    .IOBUS_WR  (IOBUS_WR),
    .RD_DATA   (RD_DATA),
    .RD_SEL    (RD_SEL),
    .TX        (TX)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = 1'b1;
    tick();
    IOBUS_WR   = 1'b0;
  endtask

  task automatic rd_status(input string name, input logic [31:0] exp);
    IOBUS_ADDR = STAT;
    #1;
    check(name, RD_DATA, exp);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 600; i++) begin
      tick();
      IOBUS_ADDR = STAT;
      #1;
      if (!RD_DATA[2]) break;
    end
    rd_status(name, 32'h0000_0002);
  endtask

  // Line monitor: cycle 0 is the first low sample; bits are sampled mid-cell (cycle 4*b+2).
  initial begin
    bit        m_busy = 1'b0;
    int        m_cnt  = 0;
    logic [7:0] m_byte = '0;
    logic [7:0] exp_b;
    forever begin
      @(negedge CLK);
      if (!RESET_N) begin
        m_busy = 1'b0;
      end else if (!m_busy) begin
        if (TX === 1'b0) begin
          m_busy = 1'b1;
          m_cnt  = 0;
        end
      end else begin
        m_cnt++;
        if (m_cnt % 4 == 2) begin
          if (m_cnt / 4 == 0) begin
            check("start_bit", 32'(TX), 32'h0);
          end else if (m_cnt / 4 <= 8) begin
            m_byte[m_cnt / 4 - 1] = TX;
          end else begin
            check("stop_bit", 32'(TX), 32'h1);
            n_frames++;
            if (sb.size() == 0) begin
              n_checks++;
              n_err++;
              $display("FAIL frame_unexpected: got byte 0x%02h expected no frame at %0t", m_byte, $time);
            end else begin
              exp_b = sb.pop_front();
              check("frame_byte", 32'(m_byte), 32'(exp_b));
            end
          end
        end
        if (m_cnt == 39) m_busy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000ns");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin
    RESET_N    = 1'b0;
    IOBUS_ADDR = STAT;
    IOBUS_OUT  = '0;
    IOBUS_WR   = 1'b0;

    // Reset
    repeat (3) @(posedge CLK);
    #1;
    check("reset_tx_in_reset", 32'(TX), 32'h1);
    RESET_N = 1'b1;
    tick();
    check("reset_tx", 32'(TX), 32'h1);
    check("reset_rdsel", 32'(RD_SEL), 32'h1);
    rd_status("reset_status", 32'h0000_0002);

    // Single byte 0x55: start bit one cycle after the write edge, 40-cycle frame.
    sb.push_back(8'h55);
    wr(BASE, 32'h55);
    check("single_tx_at_write", 32'(TX), 32'h1);
    rd_status("single_level1", 32'h0000_0100);
    tick();
    check("single_tx_fall", 32'(TX), 32'h0);
    rd_status("single_busy", 32'h0000_0006);
    repeat (39) tick();
    check("single_tx_stop", 32'(TX), 32'h1);
    rd_status("single_busy_last", 32'h0000_0006);
    tick();
    rd_status("single_done", 32'h0000_0002);

    // Back-to-back 0xA3, 0x0F: 80 cycles, no gap.
    sb.push_back(8'hA3);
    sb.push_back(8'h0F);
    wr(BASE, 32'hA3);
    wr(BASE, 32'h0F);
    rd_status("b2b_level1", 32'h0000_0104);
    repeat (79) tick();
    rd_status("b2b_busy_last", 32'h0000_0006);
    tick();
    rd_status("b2b_done", 32'h0000_0002);

    // Overflow: 10 writes, 9 accepted.
    for (int i = 0; i < 10; i++) begin
      if (i < 9) sb.push_back(8'(i));
      wr(BASE, 32'(i));
    end
    rd_status("ovf_full", 32'h0000_080D);
    wr(STAT, 32'h8);
    rd_status("ovf_clear", 32'h0000_0805);
    wait_idle("ovf_drained");

    // Address decode
    wr(BASE + 32'd8, 32'h41);
    check("dec_rdsel_off", 32'(RD_SEL), 32'h0);
    check("dec_rddata_off", RD_DATA, 32'h0);
    IOBUS_ADDR = BASE;
    #1;
    check("dec_txdata_rdsel", 32'(RD_SEL), 32'h1);
    check("dec_txdata_read", RD_DATA, 32'h0);
    IOBUS_ADDR = STAT + 32'd3;
    #1;
    check("dec_status_offset", RD_DATA, 32'h0000_0002);
    repeat (50) tick();
    rd_status("dec_no_frame", 32'h0000_0002);

    // Reset during data bit 3 of 0xFF; this frame is never expected to complete.
    wr(BASE, 32'hFF);
    repeat (19) tick();
    rd_status("midrst_busy", 32'h0000_0006);
    RESET_N = 1'b0;
    #1;
    check("midrst_tx_async", 32'(TX), 32'h1);
    rd_status("midrst_status_async", 32'h0000_0002);
    tick();
    tick();
    RESET_N = 1'b1;
    repeat (60) tick();
    check("midrst_tx_idle", 32'(TX), 32'h1);
    rd_status("midrst_status", 32'h0000_0002);

    check("frame_count", n_frames, 32'd12);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
